// File: rtl/dff_pipe_n.sv
// dff_pipe_n: elastic register pipeline of DEPTH stages, each WIDTH bits wide with its own valid
// bit. Valid/ready handshake with bubble collapsing: a stage advances when it is empty or the
// stage after it advances, so gaps close up even while the consumer stalls.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   producer has data
//   in_ready   stage 0 can accept this cycle (combinational from out_ready)
//   in_data    producer data
//   out_valid  last stage holds data
//   out_ready  consumer accepts this cycle
//   out_data   last stage data (holds its last value when empty)
//   occupancy  number of valid stages, 0..DEPTH
//
// Build option: define DFF_PIPE_SPECIFY_EN to include an annotated specify block with
// state-dependent path delays. Zero-delay behaviour is the same in both builds.

module dff_pipe_n #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0]            adv;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [OccW-1:0]             occ_q, occ_d;

  // Advance chain runs from the output end back to stage 0.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = ~valid_q[DEPTH-1] | out_ready;
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      adv[i] = ~valid_q[i] | adv[i+1];
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (adv[0]) begin
      valid_d[0] = in_valid;
      if (in_valid) data_d[0] = in_data;
    end
    for (int i = 1; i < int'(DEPTH); i++) begin
      if (adv[i]) begin
        valid_d[i] = valid_q[i-1];
        // A bubble moving forward leaves the data register untouched.
        if (valid_q[i-1]) data_d[i] = data_q[i-1];
      end
    end
    occ_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      occ_d = occ_d + OccW'(valid_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= {DEPTH{RESET_VAL}};
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      occ_q   <= occ_d;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = occ_q;

`ifdef DFF_PIPE_SPECIFY_EN
  specify
    specparam t_rise = 8:9:10, t_fall = 12:13:14, t_hold_out = 11;
    (clk => out_data) = (t_rise, t_fall);
    if (out_ready) (clk => out_valid) = t_rise;
    if (!out_ready) (clk => out_valid) = t_fall;
    (out_ready *> in_ready) = t_hold_out;
  endspecify
`else
`endif

endmodule

// File: tb/tb_dff_pipe_n.sv
module tb_dff_pipe_n;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 3;
  localparam logic [WIDTH-1:0] RESET_VAL = 8'h00;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  dff_pipe_n #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (RESET_VAL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: words in flight, oldest first, each with its stage position.
  logic [WIDTH-1:0] qd[$];
  int               qp[$];
  logic [WIDTH-1:0] last_out;

  // Output snapshot taken at the negedge of the most recent cycle.
  logic             s_out_valid, s_in_ready;
  logic [WIDTH-1:0] s_out_data;
  logic [1:0]       s_occ;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cycle(input logic rst, input logic iv, input logic [WIDTH-1:0] id,
                       input logic ordy);
    int  np[$];
    int  lim;
    logic popped, ov_e, ir_e;
    rst_n = rst; in_valid = iv; in_data = id; out_ready = ordy;
    @(negedge clk);
    s_out_valid = out_valid; s_in_ready = in_ready; s_out_data = out_data; s_occ = occupancy;
    ov_e   = (qd.size() > 0) && (qp[0] == DEPTH - 1);
    popped = ov_e && ordy;
    np.delete();
    for (int k = 0; k < qd.size(); k++) begin
      if (k == 0 && popped) begin
        np.push_back(-1);
      end else begin
        lim = (k == 0 || np[k-1] < 0) ? int'(DEPTH) : np[k-1];
        np.push_back((qp[k] + 1 < lim) ? qp[k] + 1 : qp[k]);
      end
    end
    ir_e = (np.size() == 0) || (np[np.size()-1] != 0);
    chk("out_valid", {31'b0, s_out_valid}, {31'b0, ov_e});
    chk("out_data", {24'b0, s_out_data}, {24'b0, last_out});
    chk("occupancy", {30'b0, s_occ}, qd.size());
    chk("in_ready", {31'b0, s_in_ready}, {31'b0, ir_e});
    @(posedge clk);
    if (!rst) begin
      qd.delete(); qp.delete(); last_out = RESET_VAL;
    end else begin
      for (int k = 0; k < qd.size(); k++) begin
        if (np[k] == DEPTH - 1 && qp[k] != DEPTH - 1) last_out = qd[k];
        qp[k] = np[k];
      end
      if (popped) begin
        void'(qd.pop_front()); void'(qp.pop_front());
      end
      if (iv && ir_e) begin
        qd.push_back(id); qp.push_back(0);
        if (DEPTH == 1) last_out = id;
      end
    end
    #1;
  endtask

  logic [WIDTH-1:0] bp_exp[4];
  int               bp_idx;

  initial begin
    last_out = RESET_VAL;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset for two cycles; model starts empty, so only post-reset values are checked.
    @(posedge clk); #1;
    @(posedge clk); #1;
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    chk("rst_out_valid", {31'b0, s_out_valid}, 0);
    chk("rst_occ", {30'b0, s_occ}, 0);
    chk("rst_in_ready", {31'b0, s_in_ready}, 1);
    chk("rst_out_data", {24'b0, s_out_data}, {24'b0, RESET_VAL});

    // Streaming 0x01..0x0A with latency DEPTH.
    for (int i = 0; i < 13; i++) begin
      cycle(1'b1, i < 10, 8'(i + 1), 1'b1);
      chk("stream_in_ready", {31'b0, s_in_ready}, 1);
      if (i >= 3) begin
        chk("stream_valid", {31'b0, s_out_valid}, 1);
        chk("stream_data", {24'b0, s_out_data}, i - 2);
      end
    end

    // Backpressure: three accepted, fourth refused until out_ready releases.
    bp_exp[0] = 8'hA1; bp_exp[1] = 8'hA2; bp_exp[2] = 8'hA3; bp_exp[3] = 8'hA4;
    cycle(1'b1, 1'b1, 8'hA1, 1'b0);
    cycle(1'b1, 1'b1, 8'hA2, 1'b0);
    cycle(1'b1, 1'b1, 8'hA3, 1'b0);
    cycle(1'b1, 1'b1, 8'hA4, 1'b0);
    chk("bp_full_occ", {30'b0, s_occ}, 3);
    chk("bp_full_in_ready", {31'b0, s_in_ready}, 0);
    bp_idx = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, i == 0, 8'hA4, 1'b1);
      if (s_out_valid) begin
        if (bp_idx < 4) chk("bp_order", {24'b0, s_out_data}, {24'b0, bp_exp[bp_idx]});
        bp_idx++;
      end
    end
    chk("bp_count", bp_idx, 4);

    // Bubble collapse while the consumer stalls.
    cycle(1'b1, 1'b1, 8'h55, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 8'h66, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    // 0x66 has now collapsed up behind 0x55; stage 0 is free.
    cycle(1'b1, 1'b1, 8'h70, 1'b0);
    chk("bub_occ", {30'b0, s_occ}, 2);
    chk("bub_in_ready", {31'b0, s_in_ready}, 1);
    chk("bub_head", {24'b0, s_out_data}, 8'h55);

    // Full with simultaneous accept and emit.
    cycle(1'b1, 1'b1, 8'h77, 1'b1);
    chk("full_occ", {30'b0, s_occ}, 3);
    chk("full_in_ready", {31'b0, s_in_ready}, 1);
    chk("full_emit", {24'b0, s_out_data}, 8'h55);
    cycle(1'b1, 1'b0, 8'h00, 1'b1);
    chk("full_occ_kept", {30'b0, s_occ}, 3);
    chk("full_next", {24'b0, s_out_data}, 8'h66);

    // Reset with two words held.
    cycle(1'b0, 1'b1, 8'h99, 1'b1);
    chk("mid_pre_occ", {30'b0, s_occ}, 2);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    chk("mid_occ", {30'b0, s_occ}, 0);
    chk("mid_valid", {31'b0, s_out_valid}, 0);
    chk("mid_data", {24'b0, s_out_data}, {24'b0, RESET_VAL});

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
            8'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
